// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler with a 128-entry latency scoreboard.
// Define ISSUE_STATS_EN to add dual/single issue and stall counters.
module dual_issue_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        s0_valid,
    input  logic        s0_pipe,
    input  logic [6:0]  s0_ra,
    input  logic [6:0]  s0_rb,
    input  logic [6:0]  s0_rc,
    input  logic [6:0]  s0_rt,
    input  logic [2:0]  s0_use,
    input  logic        s0_wr,
    input  logic [2:0]  s0_lat,
    input  logic [31:0] s0_instr,
    input  logic        s1_valid,
    input  logic        s1_pipe,
    input  logic [6:0]  s1_ra,
    input  logic [6:0]  s1_rb,
    input  logic [6:0]  s1_rc,
    input  logic [6:0]  s1_rt,
    input  logic [2:0]  s1_use,
    input  logic        s1_wr,
    input  logic [2:0]  s1_lat,
    input  logic [31:0] s1_instr,
    input  logic        flush,
    output logic        even_valid,
    output logic        odd_valid,
    output logic [31:0] even_instr,
    output logic [31:0] odd_instr,
    output logic [6:0]  even_rt,
    output logic [6:0]  odd_rt,
    output logic        even_wr,
    output logic        odd_wr
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0] dual_issue_cnt,
    output logic [31:0] single_issue_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef struct packed {
        logic        valid;
        logic        pipe;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic [6:0]  rt;
        logic [2:0]  srcs;
        logic        wr;
        logic [2:0]  lat;
        logic [31:0] instr;
    } entry_t;

    entry_t     b0, b1, n0, n1, e_s0, e_s1, ev_sel, od_sel;
    logic [2:0] sb [128];
    logic       rdy0, rdy1, dep, issue0, issue1, go0, go1;
    logic       accept, ev_go, od_go;

    function automatic logic srcs_ok(input logic [2:0] u, input logic [2:0] ca,
                                     input logic [2:0] cb, input logic [2:0] cc);
        return (!u[0] || ca <= 3'd1) && (!u[1] || cb <= 3'd1) && (!u[2] || cc <= 3'd1);
    endfunction

    function automatic logic [2:0] lat_eff(input logic [2:0] l);
        return (l == 3'd0) ? 3'd1 : l;
    endfunction

    assign e_s0 = '{valid: s0_valid, pipe: s0_pipe, ra: s0_ra, rb: s0_rb, rc: s0_rc,
                    rt: s0_rt, srcs: s0_use, wr: s0_wr, lat: s0_lat, instr: s0_instr};
    assign e_s1 = '{valid: s1_valid, pipe: s1_pipe, ra: s1_ra, rb: s1_rb, rc: s1_rc,
                    rt: s1_rt, srcs: s1_use, wr: s1_wr, lat: s1_lat, instr: s1_instr};

    assign rdy0 = srcs_ok(b0.srcs, sb[b0.ra], sb[b0.rb], sb[b0.rc]);
    assign rdy1 = srcs_ok(b1.srcs, sb[b1.ra], sb[b1.rb], sb[b1.rc]);
    assign dep  = b0.wr && ((b1.srcs[0] && b1.ra == b0.rt) ||
                            (b1.srcs[1] && b1.rb == b0.rt) ||
                            (b1.srcs[2] && b1.rc == b0.rt));

    assign issue0   = b0.valid && rdy0;
    assign issue1   = issue0 && b1.valid && (b1.pipe != b0.pipe) && rdy1 && !dep;
    assign go0      = issue0 && !flush;
    assign go1      = issue1 && !flush;
    assign in_ready = !b0.valid || (issue0 && (!b1.valid || issue1));
    assign accept   = in_valid && in_ready && !flush;

    // B1 is routed to its own pipe; a same-pipe B1 never dual-issues.
    assign ev_go  = (go0 && !b0.pipe) || (go1 && !b1.pipe);
    assign od_go  = (go0 && b0.pipe) || (go1 && b1.pipe);
    assign ev_sel = (go0 && !b0.pipe) ? b0 : b1;
    assign od_sel = (go0 && b0.pipe) ? b0 : b1;

    always_comb begin
        n0 = b0;
        n1 = b1;
        if (issue1) begin
            n0.valid = 1'b0;
            n1.valid = 1'b0;
        end else if (issue0) begin
            n0 = b1;
            n1.valid = 1'b0;
        end
        if (accept) begin
            if (s0_valid) begin
                n0 = e_s0;
                n1 = e_s1;
            end else begin
                n0 = e_s1;
                n1 = '0;
            end
        end
        if (flush) begin
            n0.valid = 1'b0;
            n1.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b0 <= '0;
            b1 <= '0;
        end else begin
            b0 <= n0;
            b1 <= n1;
        end
    end

    // Later assignments override the decrement; B1 wins on a shared rt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) sb[i] <= 3'd0;
        end else begin
            for (int i = 0; i < 128; i++) begin
                if (sb[i] != 3'd0) sb[i] <= sb[i] - 3'd1;
            end
            if (go0 && b0.wr) sb[b0.rt] <= lat_eff(b0.lat);
            if (go1 && b1.wr) sb[b1.rt] <= lat_eff(b1.lat);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
            even_instr <= '0;
            odd_instr  <= '0;
            even_rt    <= '0;
            odd_rt     <= '0;
            even_wr    <= 1'b0;
            odd_wr     <= 1'b0;
        end else begin
            even_valid <= ev_go;
            odd_valid  <= od_go;
            if (ev_go) begin
                even_instr <= ev_sel.instr;
                even_rt    <= ev_sel.rt;
                even_wr    <= ev_sel.wr;
            end
            if (od_go) begin
                odd_instr <= od_sel.instr;
                odd_rt    <= od_sel.rt;
                odd_wr    <= od_sel.wr;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dual_issue_cnt   <= '0;
            single_issue_cnt <= '0;
            stall_cnt        <= '0;
        end else begin
            if (go1) dual_issue_cnt <= dual_issue_cnt + 32'd1;
            if (go0 && !go1) single_issue_cnt <= single_issue_cnt + 32'd1;
            if (b0.valid && !issue0) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: directed pairs, per-pipe
// expected-issue queues checked by a negedge monitor.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        s0_valid = 0, s0_pipe = 0, s0_wr = 0;
    logic [6:0]  s0_ra = 0, s0_rb = 0, s0_rc = 0, s0_rt = 0;
    logic [2:0]  s0_use = 0, s0_lat = 0;
    logic [31:0] s0_instr = 0;
    logic        s1_valid = 0, s1_pipe = 0, s1_wr = 0;
    logic [6:0]  s1_ra = 0, s1_rb = 0, s1_rc = 0, s1_rt = 0;
    logic [2:0]  s1_use = 0, s1_lat = 0;
    logic [31:0] s1_instr = 0;
    logic        flush = 1'b0;
    logic        even_valid, odd_valid, even_wr, odd_wr;
    logic [31:0] even_instr, odd_instr;
    logic [6:0]  even_rt, odd_rt;
`ifdef ISSUE_STATS_EN
    logic [31:0] dual_issue_cnt, single_issue_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .s0_valid(s0_valid), .s0_pipe(s0_pipe), .s0_ra(s0_ra), .s0_rb(s0_rb),
        .s0_rc(s0_rc), .s0_rt(s0_rt), .s0_use(s0_use), .s0_wr(s0_wr),
        .s0_lat(s0_lat), .s0_instr(s0_instr),
        .s1_valid(s1_valid), .s1_pipe(s1_pipe), .s1_ra(s1_ra), .s1_rb(s1_rb),
        .s1_rc(s1_rc), .s1_rt(s1_rt), .s1_use(s1_use), .s1_wr(s1_wr),
        .s1_lat(s1_lat), .s1_instr(s1_instr),
        .flush(flush),
        .even_valid(even_valid), .odd_valid(odd_valid),
        .even_instr(even_instr), .odd_instr(odd_instr),
        .even_rt(even_rt), .odd_rt(odd_rt),
        .even_wr(even_wr), .odd_wr(odd_wr)
`ifdef ISSUE_STATS_EN
        ,
        .dual_issue_cnt(dual_issue_cnt),
        .single_issue_cnt(single_issue_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic        p;
        logic [6:0]  ra, rb, rc, rt;
        logic [2:0]  u;
        logic        wr;
        logic [2:0]  lat;
        logic [31:0] instr;
    } slot_t;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  rt;
        logic        wr;
        int          at_edge;
    } exp_t;

    exp_t qe[$];
    exp_t qo[$];
    exp_t ee, eo;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor: every issue strobe must match the head of its pipe's queue.
    always @(negedge clk) begin
        if (reset) begin
            if (even_valid) begin
                n_chk++;
                if (qe.size() == 0) begin
                    n_fail++;
                    $display("FAIL even_unexpected: got instr %h at edge %0d, want no issue",
                             even_instr, cyc);
                end else begin
                    ee = qe.pop_front();
                    if (even_instr !== ee.instr || even_rt !== ee.rt ||
                        even_wr !== ee.wr || cyc != ee.at_edge) begin
                        n_fail++;
                        $display("FAIL even_issue: got %h rt %0d wr %0b edge %0d, want %h rt %0d wr %0b edge %0d",
                                 even_instr, even_rt, even_wr, cyc,
                                 ee.instr, ee.rt, ee.wr, ee.at_edge);
                    end
                end
            end
            if (odd_valid) begin
                n_chk++;
                if (qo.size() == 0) begin
                    n_fail++;
                    $display("FAIL odd_unexpected: got instr %h at edge %0d, want no issue",
                             odd_instr, cyc);
                end else begin
                    eo = qo.pop_front();
                    if (odd_instr !== eo.instr || odd_rt !== eo.rt ||
                        odd_wr !== eo.wr || cyc != eo.at_edge) begin
                        n_fail++;
                        $display("FAIL odd_issue: got %h rt %0d wr %0b edge %0d, want %h rt %0d wr %0b edge %0d",
                                 odd_instr, odd_rt, odd_wr, cyc,
                                 eo.instr, eo.rt, eo.wr, eo.at_edge);
                    end
                end
            end
        end
    end

    function automatic slot_t mk(input logic p, input logic [6:0] ra, input logic [6:0] rb,
                                 input logic [6:0] rc, input logic [2:0] u,
                                 input logic [6:0] rt, input logic wr,
                                 input logic [2:0] lat, input logic [31:0] instr);
        slot_t s;
        s.v = 1'b1; s.p = p; s.ra = ra; s.rb = rb; s.rc = rc;
        s.u = u; s.rt = rt; s.wr = wr; s.lat = lat; s.instr = instr;
        return s;
    endfunction

    function automatic slot_t nil();
        slot_t s;
        s.v = 1'b0; s.p = 1'b0; s.ra = '0; s.rb = '0; s.rc = '0;
        s.u = '0; s.rt = '0; s.wr = 1'b0; s.lat = '0; s.instr = '0;
        return s;
    endfunction

    task automatic push_exp(input slot_t s, input int at);
        exp_t x;
        x.instr = s.instr; x.rt = s.rt; x.wr = s.wr; x.at_edge = at;
        if (s.p) qo.push_back(x);
        else qe.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    // Offsets are issue edges relative to acceptance; 0 means no issue expected.
    task automatic send(input slot_t a, input slot_t b, input int off_a,
                        input int off_b, output int waited);
        int k;
        s0_valid = a.v; s0_pipe = a.p; s0_ra = a.ra; s0_rb = a.rb; s0_rc = a.rc;
        s0_rt = a.rt; s0_use = a.u; s0_wr = a.wr; s0_lat = a.lat; s0_instr = a.instr;
        s1_valid = b.v; s1_pipe = b.p; s1_ra = b.ra; s1_rb = b.rb; s1_rc = b.rc;
        s1_rt = b.rt; s1_use = b.u; s1_wr = b.wr; s1_lat = b.lat; s1_instr = b.instr;
        in_valid = 1'b1;
        waited = 0;
        #1;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, want 1", waited);
        end
        k = cyc + 1;
        @(posedge clk);
        if (a.v && off_a > 0) push_exp(a, k + off_a);
        if (b.v && off_b > 0) push_exp(b, k + off_b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((qe.size() != 0 || qo.size() != 0) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 64'(qe.size() + qo.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s0c;
        s0c = 0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_valids", 64'({even_valid, odd_valid}), 64'd0);
        chk("reset_instr", {even_instr, odd_instr}, 64'd0);
        chk("reset_rt_wr", 64'({even_rt, odd_rt, even_wr, odd_wr}), 64'd0);
`ifdef ISSUE_STATS_EN
        chk("reset_stats", 64'(dual_issue_cnt | single_issue_cnt | stall_cnt), 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Independent pairs, back to back
        for (int i = 0; i < 4; i++) begin
            send(mk(0, 7'd1, 7'd2, 7'd0, 3'b011, 7'd3, 1, 3'd1, 32'hA000_0000 + i),
                 mk(1, 7'd4, 7'd0, 7'd0, 3'b001, 7'd5, 1, 3'd1, 32'hB000_0000 + i),
                 1, 1, w);
            chk("t1_in_ready_wait", 64'(w), 64'd0);
        end
        drain("t1_drain");

        // Cross-pair RAW, latency 6
`ifdef ISSUE_STATS_EN
        s0c = stall_cnt;
`endif
        send(mk(0, 7'd0, 7'd0, 7'd0, 3'b000, 7'd3, 1, 3'd6, 32'hC000_0001), nil(), 1, 0, w);
        send(mk(0, 7'd3, 7'd0, 7'd0, 3'b001, 7'd9, 1, 3'd1, 32'hC000_0002), nil(), 6, 0, w);
        chk("t2_accept_wait", 64'(w), 64'd0);
        drain("t2_drain");
`ifdef ISSUE_STATS_EN
        chk("t2_stall_delta", 64'(stall_cnt - s0c), 64'd5);
`endif

        // Same-pipe pair
        send(mk(0, 7'd0, 7'd0, 7'd0, 3'b000, 7'd10, 1, 3'd1, 32'hD000_0001),
             mk(0, 7'd0, 7'd0, 7'd0, 3'b000, 7'd11, 1, 3'd1, 32'hD000_0002), 1, 2, w);
        chk("t3_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("t3_in_ready_back", 64'(in_ready), 64'd1);
        drain("t3_drain");

        // Intra-pair dependence
        send(mk(0, 7'd0, 7'd0, 7'd0, 3'b000, 7'd7, 1, 3'd2, 32'hE000_0001),
             mk(1, 7'd7, 7'd0, 7'd0, 3'b001, 7'd8, 1, 3'd1, 32'hE000_0002), 1, 3, w);
        drain("t4_drain");

        // Flush during stall
        send(mk(0, 7'd0, 7'd0, 7'd0, 3'b000, 7'd3, 1, 3'd5, 32'hF000_0001), nil(), 1, 0, w);
        send(mk(0, 7'd3, 7'd0, 7'd0, 3'b001, 7'd12, 0, 3'd1, 32'hF000_0002), nil(), 0, 0, w);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_empty_ready", 64'(in_ready), 64'd1);
        chk("t5_no_strobe", 64'({even_valid, odd_valid}), 64'd0);
        send(mk(1, 7'd3, 7'd0, 7'd0, 3'b001, 7'd13, 0, 3'd1, 32'hF000_0003), nil(), 2, 0, w);
        drain("t5_drain");

        // Asynchronous reset mid-stall
        send(mk(0, 7'd0, 7'd0, 7'd0, 3'b000, 7'd3, 1, 3'd7, 32'h1200_0001), nil(), 1, 0, w);
        send(mk(1, 7'd3, 7'd0, 7'd0, 3'b001, 7'd14, 1, 3'd1, 32'h1200_0002), nil(), 0, 0, w);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valids", 64'({even_valid, odd_valid}), 64'd0);
        chk("t6_instr", {even_instr, odd_instr}, 64'd0);
        chk("t6_rt_wr", 64'({even_rt, odd_rt, even_wr, odd_wr}), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
`ifdef ISSUE_STATS_EN
        chk("t6_stats", 64'(dual_issue_cnt | single_issue_cnt | stall_cnt), 64'd0);
`endif
        qe.delete();
        qo.delete();
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        send(mk(0, 7'd3, 7'd0, 7'd0, 3'b001, 7'd15, 1, 3'd1, 32'h1200_0003), nil(), 1, 0, w);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
